addr_decoder_seq: RTL and testbench

Registered, parametrised successor to the combinational I/O window decoder in the Dock HDL. It captures each /IORQ cycle, decodes it against a shadowed BASE/MASK/SLOT/OP table, and holds the selected slot stable until /IORQ deasserts. Additions over the combinational decoder:
- per-window enables
- generalised slot width
- multi-hit and miss reporting
- safe mid-traffic config commit

It sits between the bus front-end and the slot chip-select/data-steering logic.

---
 rtl/addr_decoder_seq_if.sv | 31 +++
 rtl/addr_decoder_seq.sv | 189 ++++++++++++++++++
 tb/tb_addr_decoder_seq.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/addr_decoder_seq_if.sv
// rtl/addr_decoder_seq_if.sv - bus-side signals of the registered I/O window decoder
interface addr_decoder_seq_if #(
  parameter int ADDR_W      = 32,
  parameter int WIN_INDEX_W = 4,
  parameter int SLOT_W      = 3
);
  logic [ADDR_W-1:0]      addr;
  logic                   iorq_n;
  logic                   r_w_;
  logic                   busy;
  logic                   dec_valid;
  logic                   win_valid;
  logic [WIN_INDEX_W-1:0] win_index;
  logic [SLOT_W-1:0]      sel_slot;
  logic                   is_read;
  logic                   is_write;
  logic                   multi_hit;
  logic                   miss;

  modport master (
    output addr, iorq_n, r_w_,
    input  busy, dec_valid, win_valid, win_index, sel_slot,
    input  is_read, is_write, multi_hit, miss
  );

  modport slave (
    input  addr, iorq_n, r_w_,
    output busy, dec_valid, win_valid, win_index, sel_slot,
    output is_read, is_write, multi_hit, miss
  );
endinterface

// File: rtl/addr_decoder_seq.sv
// rtl/addr_decoder_seq.sv - registered I/O window decoder with shadowed config tables
// Optional per-window hit counters: define ADDR_DEC_HITCNT_EN.
module addr_decoder_seq #(
  parameter int ADDR_W      = 32,
  parameter int NUM_WIN     = 16,
  parameter int WIN_INDEX_W = 4,
  parameter int SLOT_W      = 3,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  addr_decoder_seq_if.slave         bus,
  input  logic [NUM_WIN*ADDR_W-1:0] base_flat,
  input  logic [NUM_WIN*ADDR_W-1:0] mask_flat,
  input  logic [NUM_WIN*SLOT_W-1:0] slot_flat,
  input  logic [NUM_WIN*8-1:0]      op_flat,
  input  logic [NUM_WIN-1:0]        win_en,
  input  logic                      cfg_commit,
  output logic                      cfg_pending,
  input  logic [WIN_INDEX_W-1:0]    cnt_sel,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          cnt_q
);

  typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_ACTIVE} state_t;

  state_t                    r_state;
  logic [ADDR_W-1:0]         r_addr;
  logic                      r_rw;
  logic [NUM_WIN*ADDR_W-1:0] r_base;
  logic [NUM_WIN*ADDR_W-1:0] r_mask;
  logic [NUM_WIN*SLOT_W-1:0] r_slot;
  logic [NUM_WIN*8-1:0]      r_op;
  logic [NUM_WIN-1:0]        r_en;
  logic                      r_pending;
  logic                      r_dec_valid;
  logic                      r_win_valid;
  logic [WIN_INDEX_W-1:0]    r_win_index;
  logic [SLOT_W-1:0]         r_sel_slot;
  logic                      r_is_read;
  logic                      r_is_write;
  logic                      r_multi_hit;
  logic                      r_miss;

  logic [NUM_WIN-1:0]        w_hit;
  logic [WIN_INDEX_W-1:0]    w_first_idx;
  logic [SLOT_W-1:0]         w_first_slot;
  logic                      w_any;
  logic                      w_multi;

  // 8'hFF any direction, 8'h01 reads only, 8'h00 writes only, anything else disables the window
  function automatic logic op_ok(input logic [7:0] op, input logic rd);
    case (op)
      8'hFF:   op_ok = 1'b1;
      8'h01:   op_ok = rd;
      8'h00:   op_ok = ~rd;
      default: op_ok = 1'b0;
    endcase
  endfunction

  always_comb begin
    w_hit        = '0;
    w_first_idx  = '0;
    w_first_slot = '0;
    for (int w = 0; w < NUM_WIN; w++) begin
      w_hit[w] = r_en[w]
               & (((r_addr ^ r_base[w*ADDR_W +: ADDR_W]) & r_mask[w*ADDR_W +: ADDR_W]) == '0)
               & op_ok(r_op[w*8 +: 8], r_rw);
    end
    for (int w = NUM_WIN - 1; w >= 0; w--) begin
      if (w_hit[w]) begin
        w_first_idx  = WIN_INDEX_W'(w);
        w_first_slot = r_slot[w*SLOT_W +: SLOT_W];
      end
    end
  end

  assign w_any   = |w_hit;
  assign w_multi = |(w_hit & (w_hit - NUM_WIN'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_rw        <= 1'b0;
      r_base      <= '0;
      r_mask      <= '0;
      r_slot      <= '0;
      r_op        <= '0;
      r_en        <= '0;
      r_pending   <= 1'b0;
      r_dec_valid <= 1'b0;
      r_win_valid <= 1'b0;
      r_win_index <= '0;
      r_sel_slot  <= '0;
      r_is_read   <= 1'b0;
      r_is_write  <= 1'b0;
      r_multi_hit <= 1'b0;
      r_miss      <= 1'b0;
    end else begin
      r_dec_valid <= 1'b0;
      r_miss      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Shadow load shares the capture edge, so a coincident transaction sees the new tables
          if (cfg_commit || r_pending) begin
            r_base <= base_flat;
            r_mask <= mask_flat;
            r_slot <= slot_flat;
            r_op   <= op_flat;
            r_en   <= win_en;
          end
          r_pending <= 1'b0;
          if (!bus.iorq_n) begin
            r_addr  <= bus.addr;
            r_rw    <= bus.r_w_;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_pending <= r_pending | cfg_commit;
          if (bus.iorq_n) begin
            r_state <= ST_IDLE;
          end else begin
            r_win_valid <= w_any;
            r_win_index <= w_first_idx;
            r_sel_slot  <= w_first_slot;
            r_multi_hit <= w_multi;
            r_is_read   <= r_rw;
            r_is_write  <= ~r_rw;
            r_dec_valid <= 1'b1;
            r_miss      <= ~w_any;
            r_state     <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          r_pending <= r_pending | cfg_commit;
          if (bus.iorq_n) begin
            r_win_valid <= 1'b0;
            r_win_index <= '0;
            r_sel_slot  <= '0;
            r_multi_hit <= 1'b0;
            r_is_read   <= 1'b0;
            r_is_write  <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.dec_valid = r_dec_valid;
  assign bus.win_valid = r_win_valid;
  assign bus.win_index = r_win_index;
  assign bus.sel_slot  = r_sel_slot;
  assign bus.is_read   = r_is_read;
  assign bus.is_write  = r_is_write;
  assign bus.multi_hit = r_multi_hit;
  assign bus.miss      = r_miss;
  assign cfg_pending   = r_pending;

`ifdef ADDR_DEC_HITCNT_EN
  logic [CNT_W-1:0] r_cnt [NUM_WIN];
  logic [CNT_W-1:0] r_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WIN; w++) r_cnt[w] <= '0;
      r_cnt_q <= '0;
    end else begin
      if (cnt_clr) begin
        for (int w = 0; w < NUM_WIN; w++) r_cnt[w] <= '0;
      end else if (r_state == ST_DECODE && !bus.iorq_n && w_any && r_cnt[w_first_idx] != '1) begin
        r_cnt[w_first_idx] <= r_cnt[w_first_idx] + CNT_W'(1);
      end
      r_cnt_q <= (32'(cnt_sel) < NUM_WIN) ? r_cnt[cnt_sel] : '0;
    end
  end

  assign cnt_q = r_cnt_q;
`else
  logic w_unused_cnt;
  assign w_unused_cnt = ^{cnt_sel, cnt_clr};
  assign cnt_q        = '0;
`endif

endmodule

// File: tb/tb_addr_decoder_seq.sv
// tb/tb_addr_decoder_seq.sv - directed and randomized checks of addr_decoder_seq against a table model
module tb_addr_decoder_seq;
  localparam int ADDR_W = 32, NUM_WIN = 16, WIN_INDEX_W = 4, SLOT_W = 3, CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  addr_decoder_seq_if #(.ADDR_W(ADDR_W), .WIN_INDEX_W(WIN_INDEX_W), .SLOT_W(SLOT_W)) bus ();

  logic [NUM_WIN*ADDR_W-1:0] base_flat, mask_flat;
  logic [NUM_WIN*SLOT_W-1:0] slot_flat;
  logic [NUM_WIN*8-1:0]      op_flat;
  logic [NUM_WIN-1:0]        win_en;
  logic                      cfg_commit, cfg_pending, cnt_clr;
  logic [WIN_INDEX_W-1:0]    cnt_sel;
  logic [CNT_W-1:0]          cnt_q;

  logic [31:0] st_base [NUM_WIN], st_mask [NUM_WIN], sh_base [NUM_WIN], sh_mask [NUM_WIN];
  logic [2:0]  st_slot [NUM_WIN], sh_slot [NUM_WIN];
  logic [7:0]  st_op   [NUM_WIN], sh_op   [NUM_WIN];
  logic        st_en   [NUM_WIN], sh_en   [NUM_WIN];
  int          hits    [NUM_WIN];
  int          total = 0, bad = 0;

  always_comb begin
    base_flat = '0; mask_flat = '0; slot_flat = '0; op_flat = '0; win_en = '0;
    for (int w = 0; w < NUM_WIN; w++) begin
      base_flat[w*ADDR_W +: ADDR_W] = st_base[w];
      mask_flat[w*ADDR_W +: ADDR_W] = st_mask[w];
      slot_flat[w*SLOT_W +: SLOT_W] = st_slot[w];
      op_flat[w*8 +: 8]             = st_op[w];
      win_en[w]                     = st_en[w];
    end
  end

  addr_decoder_seq #(.ADDR_W(ADDR_W), .NUM_WIN(NUM_WIN), .WIN_INDEX_W(WIN_INDEX_W),
                     .SLOT_W(SLOT_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .base_flat(base_flat), .mask_flat(mask_flat), .slot_flat(slot_flat), .op_flat(op_flat),
    .win_en(win_en), .cfg_commit(cfg_commit), .cfg_pending(cfg_pending),
    .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_q(cnt_q)
  );

`ifdef ADDR_DEC_HITCNT_EN
  addr_decoder_seq_if #(.ADDR_W(ADDR_W), .WIN_INDEX_W(WIN_INDEX_W), .SLOT_W(SLOT_W)) bus2 ();
  logic       cfg_pending2;
  logic [1:0] cnt_q2;
  assign bus2.addr   = bus.addr;
  assign bus2.iorq_n = bus.iorq_n;
  assign bus2.r_w_   = bus.r_w_;

  addr_decoder_seq #(.ADDR_W(ADDR_W), .NUM_WIN(NUM_WIN), .WIN_INDEX_W(WIN_INDEX_W),
                     .SLOT_W(SLOT_W), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .bus(bus2),
    .base_flat(base_flat), .mask_flat(mask_flat), .slot_flat(slot_flat), .op_flat(op_flat),
    .win_en(win_en), .cfg_commit(cfg_commit), .cfg_pending(cfg_pending2),
    .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_q(cnt_q2)
  );
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_shadow();
    for (int w = 0; w < NUM_WIN; w++) begin
      sh_base[w] = st_base[w]; sh_mask[w] = st_mask[w]; sh_slot[w] = st_slot[w];
      sh_op[w]   = st_op[w];   sh_en[w]   = st_en[w];
    end
  endtask

  task automatic clear_all();
    for (int w = 0; w < NUM_WIN; w++) begin
      st_base[w] = 0; st_mask[w] = 0; st_slot[w] = 0; st_op[w] = 0; st_en[w] = 0;
      sh_en[w] = 0; hits[w] = 0;
    end
  endtask

  function automatic bit op_allows(input logic [7:0] op, input logic rd);
    return (op == 8'hFF) || (op == 8'h01 && rd) || (op == 8'h00 && !rd);
  endfunction

  // Reference: scan the shadow table, first match wins, count the matches
  task automatic decode_model(input logic [31:0] a, input logic rd, output logic v,
                              output int idx, output logic [2:0] s, output logic m);
    int n = 0;
    idx = 0; s = 0;
    for (int w = 0; w < NUM_WIN; w++) begin
      if (sh_en[w] && ((a & sh_mask[w]) == (sh_base[w] & sh_mask[w])) && op_allows(sh_op[w], rd)) begin
        if (n == 0) begin idx = w; s = sh_slot[w]; end
        n++;
      end
    end
    v = (n > 0);
    m = (n > 1);
  endtask

  task automatic commit_idle();
    @(negedge clk); cfg_commit = 1'b1;
    @(negedge clk); cfg_commit = 1'b0;
    apply_shadow();
    chk("pending_after_idle_commit", cfg_pending, 0);
  endtask

  task automatic trans(input logic [31:0] a, input logic rd, input int hold, input bit commit_now);
    logic v, m; int idx; logic [2:0] s;
    @(negedge clk);
    bus.addr = a; bus.r_w_ = rd; bus.iorq_n = 1'b0;
    if (commit_now) cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    if (commit_now) apply_shadow();
    bus.addr = $urandom; bus.r_w_ = 1'($urandom);
    chk("busy_in_decode", bus.busy, 1);
    chk("dec_valid_early", bus.dec_valid, 0);
    decode_model(a, rd, v, idx, s, m);
    if (v) hits[idx]++;
    @(negedge clk);
    chk("dec_valid", bus.dec_valid, 1);
    chk("win_valid", bus.win_valid, v);
    chk("win_index", bus.win_index, idx);
    chk("sel_slot", bus.sel_slot, s);
    chk("multi_hit", bus.multi_hit, m);
    chk("miss", bus.miss, !v);
    chk("is_read", bus.is_read, rd);
    chk("is_write", bus.is_write, !rd);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("dec_valid_pulse", bus.dec_valid, 0);
      chk("miss_pulse", bus.miss, 0);
      chk("sel_slot_held", bus.sel_slot, s);
      chk("win_valid_held", bus.win_valid, v);
    end
    bus.iorq_n = 1'b1;
    @(negedge clk);
    chk("rel_win_valid", bus.win_valid, 0);
    chk("rel_sel_slot", bus.sel_slot, 0);
    chk("rel_win_index", bus.win_index, 0);
    chk("rel_multi", bus.multi_hit, 0);
    chk("rel_rd_wr", {bus.is_read, bus.is_write}, 0);
    chk("rel_busy", bus.busy, 0);
  endtask

  logic [31:0] mask_pick [4];
  logic [7:0]  op_pick [4];

  initial begin
    mask_pick[0] = 32'hFFFF_FFF0; mask_pick[1] = 32'hFFFF_FFC0;
    mask_pick[2] = 32'hFFFF_FF00; mask_pick[3] = 32'h0000_0000;
    op_pick[0] = 8'hFF; op_pick[1] = 8'h01; op_pick[2] = 8'h00; op_pick[3] = 8'h5A;
    clear_all();
    rst = 1'b1; bus.iorq_n = 1'b1; bus.addr = '0; bus.r_w_ = 1'b0;
    cfg_commit = 1'b0; cnt_sel = '0; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_outs", {bus.dec_valid, bus.win_valid, bus.win_index, bus.sel_slot, bus.is_read,
                     bus.is_write, bus.multi_hit, bus.miss, cfg_pending}, 0);
    chk("rst_cnt_q", cnt_q, 0);
    rst = 1'b0;

    // basic read hit on window 0
    st_base[0] = 32'h40; st_mask[0] = 32'hFFFF_FFF0; st_slot[0] = 5; st_op[0] = 8'hFF; st_en[0] = 1;
    commit_idle();
    trans(32'h4A, 1'b1, 1, 0);

    // overlapping windows 2 and 7
    st_base[2] = 32'h1000; st_mask[2] = 32'hFFFF_F000; st_slot[2] = 2; st_op[2] = 8'hFF; st_en[2] = 1;
    st_base[7] = 32'h1000; st_mask[7] = 32'hFFFF_F000; st_slot[7] = 6; st_op[7] = 8'hFF; st_en[7] = 1;
    commit_idle();
    trans(32'h1000, 1'b0, 2, 0);
    st_en[2] = 0;
    commit_idle();
    trans(32'h1000, 1'b1, 0, 0);

    // read-only window accessed by write, then read
    st_base[9] = 32'h2000; st_mask[9] = 32'hFFFF_F000; st_slot[9] = 4; st_op[9] = 8'h01; st_en[9] = 1;
    commit_idle();
    trans(32'h2004, 1'b0, 1, 0);
    trans(32'h2004, 1'b1, 0, 0);

    // commit during ACTIVE is deferred until IDLE
    @(negedge clk); bus.addr = 32'h4A; bus.r_w_ = 1'b1; bus.iorq_n = 1'b0;
    @(negedge clk); @(negedge clk);
    hits[0]++;
    chk("pre_commit_slot", bus.sel_slot, 5);
    st_slot[0] = 3; cfg_commit = 1'b1;
    @(negedge clk); cfg_commit = 1'b0;
    chk("pending_mid_active", cfg_pending, 1);
    chk("slot_unchanged", bus.sel_slot, 5);
    bus.iorq_n = 1'b1;
    @(negedge clk);
    chk("pending_at_release", cfg_pending, 1);
    @(negedge clk);
    chk("pending_applied", cfg_pending, 0);
    apply_shadow();
    trans(32'h4A, 1'b1, 0, 0);

    // abort in DECODE
    @(negedge clk); bus.addr = 32'h4A; bus.iorq_n = 1'b0;
    @(negedge clk); bus.iorq_n = 1'b1;
    chk("abort_busy", bus.busy, 1);
    @(negedge clk);
    chk("abort_dec_valid", bus.dec_valid, 0);
    chk("abort_miss", bus.miss, 0);
    chk("abort_idle", bus.busy, 0);
    @(negedge clk);
    chk("abort_win_valid", bus.win_valid, 0);

    // async reset while ACTIVE
    @(negedge clk); bus.addr = 32'h4A; bus.r_w_ = 1'b1; bus.iorq_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("pre_rst_win_valid", bus.win_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", {bus.busy, bus.win_valid, bus.sel_slot, bus.is_read, bus.win_index}, 0);
    bus.iorq_n = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int w = 0; w < NUM_WIN; w++) begin sh_en[w] = 0; hits[w] = 0; end
    trans(32'h4A, 1'b1, 0, 0);

`ifdef ADDR_DEC_HITCNT_EN
    for (int w = 0; w < NUM_WIN; w++) st_en[w] = 0;
    st_base[4] = 32'h300; st_mask[4] = 32'hFFFF_FF00; st_slot[4] = 1; st_op[4] = 8'hFF; st_en[4] = 1;
    commit_idle();
    for (int i = 0; i < 3; i++) trans(32'h300 + 32'(i), 1'($urandom), 0, 0);
    cnt_sel = 4;
    @(negedge clk); @(negedge clk);
    chk("cnt_three", cnt_q, 3);
    cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    for (int w = 0; w < NUM_WIN; w++) hits[w] = 0;
    @(negedge clk);
    chk("cnt_cleared", cnt_q, 0);
    chk("sat_cleared", cnt_q2, 0);
    for (int i = 0; i < 5; i++) trans(32'h3F0, 1'b1, 0, 0);
    @(negedge clk);
    chk("cnt_five", cnt_q, 5);
    chk("sat_five", cnt_q2, 3);
`endif

    // randomized tables and traffic
    for (int it = 0; it < 30; it++) begin
      bit idle_commit;
      for (int w = 0; w < NUM_WIN; w++) begin
        st_base[w] = 32'($urandom_range(0, 255)) & 32'hF0;
        st_mask[w] = mask_pick[$urandom_range(0, 3)];
        st_slot[w] = 3'($urandom);
        st_op[w]   = op_pick[$urandom_range(0, 3)];
        st_en[w]   = ($urandom_range(0, 3) != 0);
      end
      idle_commit = 1'($urandom);
      if (idle_commit) commit_idle();
      for (int t = 0; t < 4; t++)
        trans(32'($urandom_range(0, 255)), 1'($urandom), $urandom_range(0, 2), (t == 0) && !idle_commit);
    end

`ifdef ADDR_DEC_HITCNT_EN
    for (int w = 0; w < NUM_WIN; w++) begin
      cnt_sel = 4'(w);
      @(negedge clk); @(negedge clk);
      chk("cnt_rand", cnt_q, 64'(hits[w]));
      chk("sat_rand", cnt_q2, (hits[w] > 3) ? 3 : 64'(hits[w]));
    end
`else
    cnt_sel = 4'd4;
    @(negedge clk); @(negedge clk);
    chk("cnt_tied_zero", cnt_q, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
